// File: rtl/alu_unit_pkg.sv
// Shared definitions for the ALU: operation encodings plus the MIPS-style
// opcode and funct field values that the decoder recognises.
package alu_unit_pkg;

    // Decoded operation, driven out on ALUCtrl; numeric values are architectural.
    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_NOR = 5'd5,
        ALU_SLL = 5'd6,
        ALU_SRL = 5'd7,
        ALU_SRA = 5'd8,
        ALU_SLT = 5'd9
    } alu_op_e;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Funct field values, meaningful only when the opcode is OP_RTYPE
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    // Zero-pad a single compare bit out to the datapath width.
    function automatic logic [63:0] pad_bit(input logic b);
        return {63'd0, b};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder: maps OpCode/Funct onto an ALU operation
// and selects signed or unsigned comparison. Unknown encodings fall back to ADD.
module alu_decoder
    import alu_unit_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output alu_op_e    alu_ctrl,
    output logic       sign
);

    // Decode the funct field of register-register instructions.
    alu_op_e fn_ctrl;
    logic    fn_sign;

    always_comb begin
        // NOTE: both outputs get a default before the case so every path
        // assigns them; otherwise synthesis would infer latches.
        fn_ctrl = ALU_ADD;
        fn_sign = 1'b0;
        case (funct)
            FN_ADD:  begin fn_ctrl = ALU_ADD; fn_sign = 1'b1; end
            FN_ADDU: fn_ctrl = ALU_ADD;
            FN_SUB:  begin fn_ctrl = ALU_SUB; fn_sign = 1'b1; end
            FN_SUBU: fn_ctrl = ALU_SUB;
            FN_AND:  fn_ctrl = ALU_AND;
            FN_OR:   fn_ctrl = ALU_OR;
            FN_XOR:  fn_ctrl = ALU_XOR;
            FN_NOR:  fn_ctrl = ALU_NOR;
            FN_SLL:  fn_ctrl = ALU_SLL;
            FN_SRL:  fn_ctrl = ALU_SRL;
            FN_SRA:  fn_ctrl = ALU_SRA;
            FN_SLT:  begin fn_ctrl = ALU_SLT; fn_sign = 1'b1; end
            FN_SLTU: fn_ctrl = ALU_SLT;
            default: ;
        endcase
    end

    // Decode the opcode; register-register instructions defer to the funct decode.
    always_comb begin
        alu_ctrl = ALU_ADD;
        sign     = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                alu_ctrl = fn_ctrl;
                sign     = fn_sign;
            end
            OP_LW, OP_SW, OP_ADDI: begin
                alu_ctrl = ALU_ADD;
                sign     = 1'b1;
            end
            OP_ADDIU:        alu_ctrl = ALU_ADD;
            OP_ANDI:         alu_ctrl = ALU_AND;
            OP_ORI:          alu_ctrl = ALU_OR;
            OP_XORI:         alu_ctrl = ALU_XOR;
            OP_SLTI: begin
                alu_ctrl = ALU_SLT;
                sign     = 1'b1;
            end
            OP_SLTIU:        alu_ctrl = ALU_SLT;
            OP_BEQ, OP_BNE:  alu_ctrl = ALU_SUB;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle ALU with a registered result: decode is combinational, the
// result and its zero flag are captured on every rising clock edge.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [4:0]       ALUCtrl,
    output logic             Sign,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int SH_W = $clog2(WIDTH);

    alu_op_e          alu_ctrl;
    logic             sign;
    logic [SH_W-1:0]  sh;
    logic             lt;
    logic [WIDTH-1:0] out_d;
    logic             zero_d;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic [63:0]      lt_wide;

    alu_decoder u_decoder (
        .op_code  (OpCode),
        .funct    (Funct),
        .alu_ctrl (alu_ctrl),
        .sign     (sign)
    );

    assign ALUCtrl = alu_ctrl;
    assign Sign    = sign;

    // Shift amount uses only the low bits of in1; higher bits are ignored.
    assign sh = in1[SH_W-1:0];

    // Set-less-than, signed or unsigned depending on the decoded Sign.
    always_comb begin
        lt = 1'b0;
        if (sign) begin
            lt = $signed(in1) < $signed(in2);
        end else begin
            lt = in1 < in2;
        end
    end

    assign lt_wide = pad_bit(lt);

    // Result mux and the zero flag of the same result.
    always_comb begin
        out_d = in1 + in2;
        case (alu_ctrl)
            ALU_ADD: out_d = in1 + in2;
            ALU_SUB: out_d = in1 - in2;
            ALU_AND: out_d = in1 & in2;
            ALU_OR:  out_d = in1 | in2;
            ALU_XOR: out_d = in1 ^ in2;
            ALU_NOR: out_d = ~(in1 | in2);
            ALU_SLL: out_d = in2 << sh;
            ALU_SRL: out_d = in2 >> sh;
            ALU_SRA: out_d = $unsigned($signed(in2) >>> sh);
            ALU_SLT: out_d = lt_wide[WIDTH-1:0];
            default: ;
        endcase
        zero_d = (out_d == '0);
    end

    // Output register; reset clears the result asynchronously and flags zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
        end
    end

    assign out  = out_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, reset sequences,
// and randomized instructions against a table-driven arithmetic reference.
module tb_alu_unit;

    localparam longint M = 64'sh1_0000_0000;
    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4,
                   K_NOR = 5, K_SLL = 6, K_SRL = 7, K_SRA = 8, K_SLT = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op_code, funct;
    logic [31:0] in1, in2;
    logic [4:0]  alu_ctrl;
    logic        sign;
    logic [31:0] out_w;
    logic        zero_w;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference decode tables, indexed by opcode / funct value
    int op_kind[64];
    bit op_sgn[64];
    int fn_kind[64];
    bit fn_sgn[64];

    alu_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .OpCode  (op_code),
        .Funct   (funct),
        .in1     (in1),
        .in2     (in2),
        .ALUCtrl (alu_ctrl),
        .Sign    (sign),
        .out     (out_w),
        .zero    (zero_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
        logic        sgn;
        logic [31:0] res;
        logic        z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void init_tables();
        for (int i = 0; i < 64; i++) begin
            op_kind[i] = K_ADD; op_sgn[i] = 1'b0;
            fn_kind[i] = K_ADD; fn_sgn[i] = 1'b0;
        end
        op_sgn[6'h23] = 1; op_sgn[6'h2b] = 1; op_sgn[6'h08] = 1;
        op_kind[6'h0c] = K_AND; op_kind[6'h0d] = K_OR; op_kind[6'h0e] = K_XOR;
        op_kind[6'h0a] = K_SLT; op_sgn[6'h0a] = 1; op_kind[6'h0b] = K_SLT;
        op_kind[6'h04] = K_SUB; op_kind[6'h05] = K_SUB;
        fn_sgn[6'h20] = 1;
        fn_kind[6'h22] = K_SUB; fn_sgn[6'h22] = 1; fn_kind[6'h23] = K_SUB;
        fn_kind[6'h24] = K_AND; fn_kind[6'h25] = K_OR; fn_kind[6'h26] = K_XOR;
        fn_kind[6'h27] = K_NOR; fn_kind[6'h00] = K_SLL; fn_kind[6'h02] = K_SRL;
        fn_kind[6'h03] = K_SRA;
        fn_kind[6'h2a] = K_SLT; fn_sgn[6'h2a] = 1; fn_kind[6'h2b] = K_SLT;
    endfunction

    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       output int k, output bit s);
        if (op == 6'h00) begin
            k = fn_kind[fn]; s = fn_sgn[fn];
        end else begin
            k = op_kind[op]; s = op_sgn[op];
        end
    endfunction

    // Arithmetic reference: operands as plain integers, results reduced mod 2^32.
    function automatic logic [31:0] ref_result(input int k, input bit s,
                                               input logic [31:0] a, input logic [31:0] b);
        longint ua = a;
        longint ub = b;
        longint sa = (ua >= M / 2) ? ua - M : ua;
        longint sb = (ub >= M / 2) ? ub - M : ub;
        longint p2 = 1;
        longint r  = 0;
        int     sh = int'(ua % 32);
        for (int i = 0; i < sh; i++) p2 = p2 * 2;
        case (k)
            K_ADD: r = (ua + ub) % M;
            K_SUB: r = (ua - ub + M) % M;
            K_AND: r = longint'(a & b);
            K_OR:  r = longint'(a | b);
            K_XOR: r = longint'(a ^ b);
            K_NOR: r = (M - 1) - longint'(a | b);
            K_SLL: r = (ub % (M / p2)) * p2;
            K_SRL: r = ub / p2;
            K_SRA: r = ((sb >= 0) ? sb / p2 : -((-sb + p2 - 1) / p2)) + M;
            K_SLT: r = s ? ((sa < sb) ? 1 : 0) : ((ua < ub) ? 1 : 0);
            default: r = 0;
        endcase
        r = r % M;
        return r[31:0];
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_code = op; funct = fn; in1 = a; in2 = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [5:0]  op_list[14];
    logic [5:0]  fn_list[14];

    initial begin
        int          k;
        bit          s;
        logic [5:0]  op, fn;
        logic [31:0] a, b, exp_r;

        init_tables();
        reset = 1'b1;
        op_code = '0; funct = 6'h20; in1 = '0; in2 = '0;

        // Reset is asynchronous: outputs are cleared before any clock edge.
        #1;
        check("reset_out_no_edge", out_w, 32'h0);
        check("reset_zero_no_edge", {31'd0, zero_w}, 32'h1);
        step();
        check("reset_out_held", out_w, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        vecs.push_back('{"lw",        6'h23, 6'h27, 32'h00001100, 32'h00000010, 5'd0, 1'b1, 32'h00001110, 1'b0});
        vecs.push_back('{"nor",       6'h00, 6'h27, 32'hF0000001, 32'h00001101, 5'd5, 1'b0, 32'h0FFFEEFE, 1'b0});
        vecs.push_back('{"sra",       6'h00, 6'h03, 32'h00000001, 32'hF0000100, 5'd8, 1'b0, 32'hF8000080, 1'b0});
        vecs.push_back('{"slt",       6'h00, 6'h2a, 32'hF0000100, 32'h00000001, 5'd9, 1'b1, 32'h00000001, 1'b0});
        vecs.push_back('{"sltu",      6'h00, 6'h2b, 32'hF0000100, 32'h00000001, 5'd9, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{"slti",      6'h0a, 6'h00, 32'h00000100, 32'hFFFFF001, 5'd9, 1'b1, 32'h00000000, 1'b1});
        vecs.push_back('{"sltiu",     6'h0b, 6'h2a, 32'h00000100, 32'h0000F001, 5'd9, 1'b0, 32'h00000001, 1'b0});
        vecs.push_back('{"beq",       6'h04, 6'h20, 32'h00000100, 32'h00000100, 5'd1, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{"bne",       6'h05, 6'h00, 32'h00000005, 32'h00000003, 5'd1, 1'b0, 32'h00000002, 1'b0});
        vecs.push_back('{"add_wrap",  6'h00, 6'h20, 32'hFFFFFFFF, 32'h00000001, 5'd0, 1'b1, 32'h00000000, 1'b1});
        vecs.push_back('{"subu_wrap", 6'h00, 6'h23, 32'h00000000, 32'h00000001, 5'd1, 1'b0, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"sub",       6'h00, 6'h22, 32'h00000010, 32'h00000003, 5'd1, 1'b1, 32'h0000000D, 1'b0});
        vecs.push_back('{"sll_by32",  6'h00, 6'h00, 32'h00000020, 32'h00001234, 5'd6, 1'b0, 32'h00001234, 1'b0});
        vecs.push_back('{"sll",       6'h00, 6'h00, 32'hFFFFFFE4, 32'h80000011, 5'd6, 1'b0, 32'h00000110, 1'b0});
        vecs.push_back('{"srl",       6'h00, 6'h02, 32'h00000024, 32'h80000000, 5'd7, 1'b0, 32'h08000000, 1'b0});
        vecs.push_back('{"andi",      6'h0c, 6'h25, 32'hFF00FF00, 32'h00000F0F, 5'd2, 1'b0, 32'h00000F00, 1'b0});
        vecs.push_back('{"ori",       6'h0d, 6'h00, 32'h000000F0, 32'h0000000F, 5'd3, 1'b0, 32'h000000FF, 1'b0});
        vecs.push_back('{"xori",      6'h0e, 6'h00, 32'h000000FF, 32'h000000FF, 5'd4, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{"addi",      6'h08, 6'h00, 32'h00000007, 32'hFFFFFFFF, 5'd0, 1'b1, 32'h00000006, 1'b0});
        vecs.push_back('{"addiu",     6'h09, 6'h00, 32'h00000001, 32'h00000001, 5'd0, 1'b0, 32'h00000002, 1'b0});
        vecs.push_back('{"sw",        6'h2b, 6'h00, 32'h00000004, 32'h00000004, 5'd0, 1'b1, 32'h00000008, 1'b0});
        vecs.push_back('{"bad_op",    6'h3f, 6'h22, 32'h00000002, 32'h00000003, 5'd0, 1'b0, 32'h00000005, 1'b0});
        vecs.push_back('{"bad_funct", 6'h00, 6'h01, 32'h00000002, 32'h00000003, 5'd0, 1'b0, 32'h00000005, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_ctrl"}, {27'd0, alu_ctrl}, {27'd0, vecs[i].ctrl});
            check({vecs[i].name, "_sign"}, {31'd0, sign}, {31'd0, vecs[i].sgn});
            step();
            check({vecs[i].name, "_out"}, out_w, vecs[i].res);
            check({vecs[i].name, "_zero"}, {31'd0, zero_w}, {31'd0, vecs[i].z});
        end

        // Reset mid-cycle after an add: cleared at once, decode unaffected.
        drive(6'h00, 6'h20, 32'h0BCF0000, 32'h00001110);
        step();
        check("pre_reset_out", out_w, 32'h0BCF1110);
        #2;
        reset = 1'b1;
        #1;
        check("midcycle_reset_out", out_w, 32'h0);
        check("midcycle_reset_zero", {31'd0, zero_w}, 32'h1);
        check("reset_ctrl_kept", {27'd0, alu_ctrl}, 32'h0);
        check("reset_sign_kept", {31'd0, sign}, 32'h1);
        drive(6'h00, 6'h25, 32'h00000A00, 32'h0000000B);
        step();
        check("reset_held_edge_out", out_w, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("first_after_reset_out", out_w, 32'h00000A0B);
        check("first_after_reset_zero", {31'd0, zero_w}, 32'h0);

        // Short reset pulse between edges discards the registered result.
        drive(6'h00, 6'h24, 32'h0000FFFF, 32'h00001234);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("pulse_reset_out", out_w, 32'h0);
        check("pulse_reset_zero", {31'd0, zero_w}, 32'h1);
        step();
        check("after_pulse_out", out_w, 32'h00001234);

        // Randomized instructions against the reference model.
        op_list = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h09,
                    6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h04, 6'h05};
        fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                    6'h27, 6'h00, 6'h02, 6'h03, 6'h2a, 6'h2b, 6'h01};
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 15);
            op = (r < 14) ? op_list[r] : 6'($urandom_range(0, 63));
            r  = $urandom_range(0, 15);
            fn = (r < 14) ? fn_list[r] : 6'($urandom_range(0, 63));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: begin a = $urandom_range(0, 40); b = $urandom_range(0, 40); end
                1: b = a;
                2: b = ~a + 32'd1;
                default: ;
            endcase
            ref_decode(op, fn, k, s);
            exp_r = ref_result(k, s, a, b);
            drive(op, fn, a, b);
            check("rand_ctrl", {27'd0, alu_ctrl}, k[31:0]);
            check("rand_sign", {31'd0, sign}, {31'd0, s});
            step();
            check("rand_out", out_w, exp_r);
            check("rand_zero", {31'd0, zero_w}, {31'd0, (exp_r == 32'h0)});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
